// File: rtl/eth_tx_pkg.sv
// Shared types and default widths for the Ethernet frame writer.
package eth_tx_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_LEN_WIDTH  = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned MAC_WIDTH      = 48;
    localparam int unsigned ETH_TYPE_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [MAC_WIDTH-1:0]      dest_mac;
        logic [MAC_WIDTH-1:0]      src_mac;
        logic [ETH_TYPE_WIDTH-1:0] eth_type;
    } eth_hdr_t;

endpackage

// File: rtl/payload_skid.sv
// Two-entry output buffer with registered outputs; emptied entries read back as zero.
module payload_skid #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] spare_q, spare_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             pop;

    always_comb begin
        head_d  = head_q;
        spare_d = spare_q;
        cnt_d   = cnt_q;
        pop     = valid_q && pop_ready;
        case ({push_valid, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_data;
                    cnt_d  = 2'd1;
                end else begin
                    spare_d = push_data;
                    cnt_d   = 2'd2;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d  = spare_q;
                    spare_d = '0;
                    cnt_d   = 2'd1;
                end else begin
                    head_d = '0;
                    cnt_d  = 2'd0;
                end
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d  = spare_q;
                    spare_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: ;
        endcase
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            spare_q <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            spare_q <= spare_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign count     = cnt_q;

endmodule

// File: rtl/write_frame_func.sv
// Sends one Ethernet frame: header handshake, then payload beats read from a
// one-cycle-latency memory through a skid buffer, then a completion pulse.
module write_frame_func
    import eth_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic [47:0]           dest_mac,
    input  logic [47:0]           src_mac,
    input  logic [15:0]           eth_type,
    input  logic [LEN_WIDTH-1:0]  payload_len,
    output logic [ADDR_WIDTH-1:0] pay_raddr,
    input  logic [DATA_WIDTH-1:0] pay_rdata,
    output logic                  valid,
    output logic                  s_eth_hdr_valid,
    input  logic                  s_eth_hdr_ready,
    output logic [47:0]           s_eth_dest_mac,
    output logic [47:0]           s_eth_src_mac,
    output logic [15:0]           s_eth_type,
    output logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    output logic                  s_eth_payload_axis_tvalid,
    input  logic                  s_eth_payload_axis_tready,
    output logic                  s_eth_payload_axis_tlast,
    output logic                  s_eth_payload_axis_tuser,
    input  logic                  busy
);

    localparam int unsigned SKID_WIDTH = DATA_WIDTH + 1;

    state_e                state_q, state_d;
    eth_hdr_t              hdr_q, hdr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_last_q, rd_last_d;
    logic [ADDR_WIDTH-1:0] pay_raddr_q, pay_raddr_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  hdr_valid_q, hdr_valid_d;

    logic                  skid_valid;
    logic [SKID_WIDTH-1:0] skid_data;
    logic [1:0]            skid_count;
    logic                  beat_xfer;
    logic                  issue;
    logic [2:0]            fill;

    payload_skid #(.WIDTH(SKID_WIDTH)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (rd_pend_q),
        .push_data  ({rd_last_q, pay_rdata}),
        .pop_ready  (s_eth_payload_axis_tready),
        .out_valid  (skid_valid),
        .out_data   (skid_data),
        .count      (skid_count)
    );

    // A read is issued only if the skid still has a free slot when its data lands.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        rd_pend_d  = 1'b0;
        rd_last_d  = rd_last_q;
        issue      = 1'b0;
        beat_xfer  = skid_valid && s_eth_payload_axis_tready;
        fill       = 3'(skid_count) + 3'(rd_pend_q) - 3'(beat_xfer);

        case (state_q)
            ST_IDLE: begin
                if (start && !busy) begin
                    state_d        = ST_HDR;
                    hdr_d.dest_mac = dest_mac;
                    hdr_d.src_mac  = src_mac;
                    hdr_d.eth_type = eth_type;
                    len_d          = payload_len;
                    rd_cnt_d       = '0;
                    beat_cnt_d     = '0;
                end
            end
            ST_HDR: begin
                if (s_eth_hdr_ready) begin
                    state_d = (len_q == '0) ? ST_DONE : ST_PAYLOAD;
                    issue   = (len_q != '0);
                end
            end
            ST_PAYLOAD: begin
                issue = (rd_cnt_q < len_q) && (fill <= 3'd1);
                if (beat_xfer) begin
                    beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    if (beat_cnt_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                rd_cnt_d   = '0;
                beat_cnt_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            rd_cnt_d  = rd_cnt_q + LEN_WIDTH'(1);
            rd_pend_d = 1'b1;
            rd_last_d = (rd_cnt_q == len_q - LEN_WIDTH'(1));
        end

        // Header bus reads as zero whenever it is not being offered.
        if (state_d != ST_HDR) begin
            hdr_d = '0;
        end

        ready_d     = (state_d == ST_IDLE);
        hdr_valid_d = (state_d == ST_HDR);
        valid_d     = (state_d == ST_DONE);
        pay_raddr_d = ADDR_WIDTH'(rd_cnt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_q       <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            pay_raddr_q <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            hdr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            pay_raddr_q <= pay_raddr_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            hdr_valid_q <= hdr_valid_d;
        end
    end

    assign ready                     = ready_q;
    assign valid                     = valid_q;
    assign pay_raddr                 = pay_raddr_q;
    assign s_eth_hdr_valid           = hdr_valid_q;
    assign s_eth_dest_mac            = hdr_q.dest_mac;
    assign s_eth_src_mac             = hdr_q.src_mac;
    assign s_eth_type                = hdr_q.eth_type;
    assign s_eth_payload_axis_tvalid = skid_valid;
    assign s_eth_payload_axis_tdata  = skid_data[DATA_WIDTH-1:0];
    assign s_eth_payload_axis_tlast  = skid_data[DATA_WIDTH];
    assign s_eth_payload_axis_tuser  = 1'b0;

endmodule

// File: doc/write_frame_func.md
WRITE_FRAME_FUNC -- requirements
Module: write_frame_func

Interface
REQ-001 Parameter DATA_WIDTH, 8, payload beat width in bits.
REQ-002 Parameter LEN_WIDTH, 16, width of payload length in beats.
REQ-003 Parameter ADDR_WIDTH, 16, width of payload memory read address.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request to send one frame; accepted when start && ready.
REQ-008 ready  out  1  high only in IDLE.
REQ-009 dest_mac  in  48, src_mac  in  48, eth_type  in  16: header fields, sampled on acceptance.
REQ-010 payload_len  in  LEN_WIDTH  number of payload beats, sampled on acceptance.
REQ-011 pay_raddr  out  ADDR_WIDTH; pay_rdata  in  DATA_WIDTH: payload memory, read data valid exactly 1 cycle after address.
REQ-012 valid  out  1  one-cycle completion pulse.
REQ-013 s_eth_hdr_valid  out  1; s_eth_hdr_ready  in  1; s_eth_dest_mac  out  48; s_eth_src_mac  out  48; s_eth_type  out  16.
REQ-014 s_eth_payload_axis_tdata  out  DATA_WIDTH; _tvalid  out  1; _tready  in  1; _tlast  out  1; _tuser  out  1.
REQ-015 busy  in  1  transmitter busy; start SHALL NOT be accepted while busy is high.

Function
REQ-016 States: IDLE, HDR, PAYLOAD, DONE.
REQ-017 IDLE -> HDR on start && !busy; header fields and payload_len captured into registers in that cycle.
REQ-018 In HDR, s_eth_hdr_valid=1 with captured fields held stable until the cycle s_eth_hdr_ready=1 (handshake); then PAYLOAD if len>0, else DONE.
REQ-019 Header outputs SHALL be 0 whenever s_eth_hdr_valid=0.
REQ-020 PAYLOAD issues reads at addresses 0..len-1 in order, issuing a read only when the output stage has guaranteed room (no beat dropped under backpressure).
REQ-021 First tvalid SHALL appear 2 cycles after the header handshake cycle; with tready held high, one beat per cycle thereafter.
REQ-022 Beat k carries pay_rdata from address k; tdata/tlast held stable while tvalid && !tready.
REQ-023 tlast=1 on beat len-1 only; tuser=0 always.
REQ-024 Beat transfers when tvalid && tready; after last beat transfers, -> DONE.
REQ-025 DONE: valid=1 for exactly one cycle, then IDLE.
REQ-026 Beat counter and address counter are LEN_WIDTH wide; payload_len=2^LEN_WIDTH-1 SHALL complete without wrap.
REQ-027 start asserted outside IDLE SHALL be ignored; input field changes after acceptance SHALL NOT affect the frame in flight.
REQ-028 s_eth_hdr_ready or tready asserted outside HDR/PAYLOAD SHALL have no effect.

Reset
REQ-029 rst SHALL, in any state including mid-frame, force IDLE and clear counters and the skid buffer.
REQ-030 Reset values: ready=1 (after reset); valid, hdr_valid, tvalid, tlast, tuser=0; header, tdata and pay_raddr outputs=0.

Structure
REQ-031 State encoding and default parameter constants SHALL reside in shared package eth_tx_pkg.
REQ-032 The output stage SHALL be a separate 2-entry skid buffer sub-module, payload_skid, parametrised by DATA_WIDTH+1 (data+last).

Verification
REQ-033 len=4, mem=11,22,33,44, hdr_ready immediate, tready=1 -> hdr fields match; beats 11,22,33,44 on consecutive cycles, tlast on 44, valid pulse once.
REQ-034 len=0 -> header handshake only, no tvalid, valid pulses the cycle after the handshake.
REQ-035 len=6, tready toggling 1,0,0,1,0,1... -> all 6 beats in order, none duplicated or lost, tdata stable while stalled.
REQ-036 hdr_ready held low 10 cycles, dest_mac input changed after start -> hdr_valid held 10 cycles with the original captured fields.
REQ-037 rst asserted on the 3rd payload beat of a len=8 frame -> next cycle IDLE, all outputs at reset values; a new len=2 frame then completes correctly.
REQ-038 start with busy=1 -> not accepted (ready stays 1, no hdr_valid); accepted in the first cycle busy=0.
